// File: rtl/dpsram_responder.sv
// dpsram_responder: true dual-port word RAM with registered (READ_FIRST) reads,
// byte-lane writes, port-A-wins collision merging, out-of-range detection and
// a post-reset zero-fill sweep that gates all traffic until it completes.
//
// Handshake: there is no valid/ready flow control on the ports. An access is
// taken on every clock edge where ready=1 and x_en=1, with no back-pressure.
// While ready=0 the ports are ignored entirely.
module dpsram_responder #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AWIDTH-1:0]   a_addr,
    input  logic [DWIDTH-1:0]   a_din,
    input  logic [DWIDTH/8-1:0] a_we,
    input  logic                a_en,
    input  logic                a_rst,
    output logic [DWIDTH-1:0]   a_dout,
    input  logic [AWIDTH-1:0]   b_addr,
    input  logic [DWIDTH-1:0]   b_din,
    input  logic [DWIDTH/8-1:0] b_we,
    input  logic                b_en,
    output logic [DWIDTH-1:0]   b_dout,
    output logic                ready,
    output logic                oob_err
);

    localparam int NB = DWIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range limit one bit wider than the address so DEPTH always fits.
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH + 1)'(DEPTH);
    localparam logic [IW-1:0]   LAST  = IW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              a_inr, b_inr;
    logic              a_act, b_act;
    logic [IW-1:0]     a_idx, b_idx;
    logic [DWIDTH-1:0] a_rd, b_rd;
    logic [DWIDTH-1:0] a_q1, b_q1;

    // Range check uses the full address; only then are the low bits decoded.
    assign a_inr = ({1'b0, a_addr} < LIMIT);
    assign b_inr = ({1'b0, b_addr} < LIMIT);
    assign a_idx = a_addr[IW-1:0];
    assign b_idx = b_addr[IW-1:0];
    assign a_act = (state == READY) && a_en;
    assign b_act = (state == READY) && b_en;
    assign ready = (state == READY);

    // Pre-edge contents: reads are READ_FIRST, out-of-range reads return 0.
    assign a_rd = a_inr ? mem[a_idx] : '0;
    assign b_rd = b_inr ? mem[b_idx] : '0;

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next state: walk the pointer across every word, then sit in READY.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == LAST) begin
                    state_nx = READY;
                    ptr_nx   = '0;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            READY: begin
                state_nx = READY;
            end
            default: begin
                state_nx = CLEAR;
                ptr_nx   = '0;
            end
        endcase
    end

    // Storage: zero-fill during the sweep, then byte-lane writes. Port B is
    // applied first so port A's lane overrides it when both target a lane.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_act && b_inr && b_we[i])
                    mem[b_idx][i*8 +: 8] <= b_din[i*8 +: 8];
                if (a_act && a_inr && a_we[i])
                    mem[a_idx][i*8 +: 8] <= a_din[i*8 +: 8];
            end
        end
    end

    // First read stage for both ports; a_rst clears port A's register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q1 <= '0;
            b_q1 <= '0;
        end else begin
            if (a_act)
                a_q1 <= a_rst ? '0 : a_rd;
            if (b_act)
                b_q1 <= b_rd;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DWIDTH-1:0] a_q2, b_q2;

            // Second output stage; advances only on enabled cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q2 <= '0;
                    b_q2 <= '0;
                end else begin
                    if (a_act)
                        a_q2 <= a_rst ? '0 : a_q1;
                    if (b_act)
                        b_q2 <= b_q1;
                end
            end

            assign a_dout = a_q2;
            assign b_dout = b_q2;
        end else begin : g_lat1
            assign a_dout = a_q1;
            assign b_dout = b_q1;
        end
    endgenerate

    // Sticky out-of-range flag, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oob_err <= 1'b0;
        else if ((a_act && !a_inr) || (b_act && !b_inr))
            oob_err <= 1'b1;
    end

endmodule

// File: tb/tb_dpsram_responder.sv
// Directed testbench for dpsram_responder (DEPTH=16, READ_LAT=1).
module tb_dpsram_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DP = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [3:0]    a_we, b_we;
    logic          a_en, b_en, a_rst;
    logic [DW-1:0] a_dout, b_dout;
    logic          ready, oob_err;

    int n_checks = 0;
    int n_fail   = 0;

    dpsram_responder #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP), .READ_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_din(a_din), .a_we(a_we), .a_en(a_en), .a_rst(a_rst),
        .a_dout(a_dout),
        .b_addr(b_addr), .b_din(b_din), .b_we(b_we), .b_en(b_en),
        .b_dout(b_dout),
        .ready(ready), .oob_err(oob_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 0; a_we = '0; a_rst = 0; a_addr = '0; a_din = '0;
        b_en = 0; b_we = '0; b_addr = '0; b_din = '0;
    endtask

    // One port-A access for one edge, then idle.
    task automatic a_op(input logic [AW-1:0] addr, input logic [DW-1:0] din,
                        input logic [3:0] we, input logic rst);
        a_en = 1; a_addr = addr; a_din = din; a_we = we; a_rst = rst;
        cyc();
        a_en = 0; a_we = '0; a_rst = 0;
    endtask

    // Count edges from reset release until ready (bounded).
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 100) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        rst_n = 0;
        #13;
        n_checks++;
        if (a_dout !== '0 || b_dout !== '0 || ready !== 1'b0 || oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: a_dout=%h b_dout=%h ready=%b oob=%b, required all 0",
                     a_dout, b_dout, ready, oob_err);
        end
        @(posedge clk); #1;
        rst_n = 1;
        wait_ready(cnt);
        n_checks++;
        if (cnt !== DP) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d cycles, required %0d", cnt, DP);
        end
        for (int i = 0; i < DP; i++) begin
            a_op(i, '0, 4'h0, 0);
            n_checks++;
            if (a_dout !== '0) begin
                n_fail++;
                $display("FAIL zero_fill[%0d]: a_dout=%h, required 0", i, a_dout);
            end
        end
    endtask

    task automatic test_write_read();
        a_op(5, 32'hDEADBEEF, 4'hF, 0);
        a_op(5, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL a_write_read: a_dout=%h, required deadbeef", a_dout);
        end
        b_en = 1; b_addr = 5;
        cyc();
        b_en = 0;
        n_checks++;
        if (b_dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL b_read_of_a_write: b_dout=%h, required deadbeef", b_dout);
        end
    endtask

    task automatic test_byte_lanes();
        a_op(7, 32'hAAAAAAAA, 4'hF, 0);
        a_op(7, 32'h11223344, 4'b0011, 0);
        n_checks++;
        if (a_dout !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL read_first: a_dout=%h, required aaaaaaaa", a_dout);
        end
        a_op(7, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'hAAAA3344) begin
            n_fail++;
            $display("FAIL byte_lanes: a_dout=%h, required aaaa3344", a_dout);
        end
    endtask

    task automatic test_collision();
        // Both ports write all lanes: A wins.
        a_en = 1; a_addr = 9; a_din = 32'h11111111; a_we = 4'hF;
        b_en = 1; b_addr = 9; b_din = 32'h22222222; b_we = 4'hF;
        cyc();
        idle();
        a_op(9, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'h11111111) begin
            n_fail++;
            $display("FAIL collide_full: a_dout=%h, required 11111111", a_dout);
        end
        // Disjoint lanes merge.
        a_en = 1; a_addr = 9; a_din = 32'h11111111; a_we = 4'b0111;
        b_en = 1; b_addr = 9; b_din = 32'h22222222; b_we = 4'b1000;
        cyc();
        idle();
        a_op(9, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'h22111111) begin
            n_fail++;
            $display("FAIL collide_merge: a_dout=%h, required 22111111", a_dout);
        end
        // A reads while B writes the same word: A sees old data.
        a_en = 1; a_addr = 9; a_we = 4'h0;
        b_en = 1; b_addr = 9; b_din = 32'h33333333; b_we = 4'hF;
        cyc();
        idle();
        n_checks++;
        if (a_dout !== 32'h22111111) begin
            n_fail++;
            $display("FAIL cross_read_old: a_dout=%h, required 22111111", a_dout);
        end
        // Overlapping lane 0 goes to A, lane 1 only from B, lanes 2-3 untouched.
        a_en = 1; a_addr = 9; a_din = 32'h000000AA; a_we = 4'b0001;
        b_en = 1; b_addr = 9; b_din = 32'h0000BBCC; b_we = 4'b0011;
        cyc();
        idle();
        b_en = 1; b_addr = 9;
        cyc();
        idle();
        n_checks++;
        if (b_dout !== 32'h3333BBAA) begin
            n_fail++;
            $display("FAIL lane_priority: b_dout=%h, required 3333bbaa", b_dout);
        end
    endtask

    task automatic test_oob();
        a_op(0, 32'h12345678, 4'hF, 0);
        a_op(9, '0, 4'h0, 0);
        n_checks++;
        if (oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_before: oob_err=%b, required 0", oob_err);
        end
        a_op(DP + 3, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== '0 || oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_read: a_dout=%h oob=%b, required 0 and 1", a_dout, oob_err);
        end
        // Write to DEPTH must not alias onto word 0.
        a_op(DP, 32'hFFFFFFFF, 4'hF, 0);
        a_op(0, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'h12345678) begin
            n_fail++;
            $display("FAIL oob_no_alias: a_dout=%h, required 12345678", a_dout);
        end
        repeat (3) cyc();
        n_checks++;
        if (oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: oob_err=%b, required 1", oob_err);
        end
    endtask

    task automatic test_en_hold();
        a_op(5, '0, 4'h0, 0);
        a_addr = 0; a_din = 32'h55555555; a_we = 4'hF;
        repeat (3) cyc();
        idle();
        n_checks++;
        if (a_dout !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL en_hold: a_dout=%h, required deadbeef", a_dout);
        end
        a_op(0, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'h12345678) begin
            n_fail++;
            $display("FAIL en_low_no_write: a_dout=%h, required 12345678", a_dout);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        rst_n = 0;
        #3;
        n_checks++;
        if (oob_err !== 1'b0 || ready !== 1'b0 || a_dout !== '0) begin
            n_fail++;
            $display("FAIL reset_async: oob=%b ready=%b a_dout=%h, required 0", oob_err, ready, a_dout);
        end
        @(posedge clk); #1;
        rst_n = 1;
        // Traffic during the sweep is ignored, including out-of-range.
        a_en = 1; a_addr = DP + 1; a_we = 4'h0;
        repeat (8) cyc();
        idle();
        n_checks++;
        if (ready !== 1'b0 || oob_err !== 1'b0 || a_dout !== '0) begin
            n_fail++;
            $display("FAIL clear_ignores: ready=%b oob=%b a_dout=%h, required 0", ready, oob_err, a_dout);
        end
        rst_n = 0;
        #2;
        rst_n = 1;
        wait_ready(cnt);
        n_checks++;
        if (cnt !== DP) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d cycles, required %0d", cnt, DP);
        end
        a_op(12, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== '0) begin
            n_fail++;
            $display("FAIL restart_zero: a_dout=%h, required 0", a_dout);
        end
        a_op(3, 32'hCAFEF00D, 4'hF, 0);
        a_op(3, '0, 4'h0, 0);
        a_op(3, '0, 4'h0, 1);
        n_checks++;
        if (a_dout !== '0) begin
            n_fail++;
            $display("FAIL a_rst_read: a_dout=%h, required 0", a_dout);
        end
        // a_rst clears output but the write still lands.
        a_op(4, 32'h0BADC0DE, 4'hF, 1);
        a_op(4, '0, 4'h0, 0);
        n_checks++;
        if (a_dout !== 32'h0BADC0DE) begin
            n_fail++;
            $display("FAIL a_rst_write: a_dout=%h, required 0badc0de", a_dout);
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_collision();
        test_oob();
        test_en_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
